text_write_sequencer: RTL

- Sequences character-table writes into the font renderer's character RAM from a byte-stream (valid/ready) source such as a UART RX or a test-pattern generator.
- Tracks a text cursor (column/row) and interprets control codes: newline, carriage return, backspace, form-feed/clear.
- Drives the renderer's write port: write enable, character code, x position, y position.
- Sits between the text producer and the renderer. It is the only writer of the character table.

---
 rtl/font_text_pkg.sv | 20 ++
 rtl/text_cursor.sv | 79 +++++++
 rtl/text_write_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/font_text_pkg.sv
// -----------------------------------------------------------------------------
// font_text_pkg
// Shared definitions for the text write sequencer: control-code values
// recognised in the incoming byte stream, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package font_text_pkg;

  localparam logic [7:0] CC_BS = 8'h08;  // backspace
  localparam logic [7:0] CC_LF = 8'h0A;  // line feed
  localparam logic [7:0] CC_FF = 8'h0C;  // form feed, clears the table
  localparam logic [7:0] CC_CR = 8'h0D;  // carriage return

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// -----------------------------------------------------------------------------
// text_cursor
// Column/row cursor for the character table. There is no scrolling, so every
// movement wraps inside the table. The wraps compare against COLUMNS-1 and
// ROWS-1 explicitly because the sizes are not generally powers of two.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   advance           step one cell forward (row-major, wraps to (0,0))
//   retreat           step one cell back (stays at (0,0))
//   newline           x=0, next row (wraps to row 0)
//   carriage_return   x=0
//   home              force (0,0); takes priority over everything else
//   x, y              current cursor position
// -----------------------------------------------------------------------------
module text_cursor #(
  parameter  int COLUMNS = 12,
  parameter  int ROWS    = 2,
  localparam int XW      = $clog2(COLUMNS),
  localparam int YW      = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          retreat,
  input  logic          newline,
  input  logic          carriage_return,
  input  logic          home,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          x_last;
  logic          y_last;

  assign x_last = (x == XW'(COLUMNS - 1));
  assign y_last = (y == YW'(ROWS - 1));

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (home) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (advance) begin
      if (x_last) begin
        x_nxt = '0;
        y_nxt = y_last ? '0 : y + YW'(1);
      end else begin
        x_nxt = x + XW'(1);
      end
    end else if (retreat) begin
      if (x != '0) begin
        x_nxt = x - XW'(1);
      end else if (y != '0) begin
        x_nxt = XW'(COLUMNS - 1);
        y_nxt = y - YW'(1);
      end
    end else if (newline) begin
      x_nxt = '0;
      y_nxt = y_last ? '0 : y + YW'(1);
    end else if (carriage_return) begin
      x_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/text_write_sequencer.sv
// -----------------------------------------------------------------------------
// text_write_sequencer
// Turns a valid/ready character stream into writes on the renderer's
// character-table port, tracking a text cursor and interpreting LF, CR, BS
// and FF. It is the only writer of the character table.
//
// Optional build macro: CHAR_WR_VBLANK_ONLY_EN
//   When defined, table writes happen only while i_vblank=1: printable
//   characters wait in HOLD and the clear sweep pauses during active video.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_char, i_char_valid  incoming character / control code
//   o_char_ready          character accepted this cycle when valid is high
//   i_clear               one-cycle request to clear the whole table
//   i_vblank              vertical blanking flag (macro build only)
//   o_wr_en               character-table write strobe
//   o_wr_character        code to write
//   o_wr_x_pos/y_pos      write address
//   o_cur_x/o_cur_y       current cursor position
//   o_busy                clear in progress or write pending
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a character; control codes are consumed here
// WRITE | one write strobe for the character latched at acceptance
// CLEAR | row-major sweep writing CLEAR_CHAR to every cell
// HOLD  | character latched, waiting for vblank (macro build only)
// -----------------------------------------------------------------------------
module text_write_sequencer
  import font_text_pkg::*;
#(
  parameter  int         COLUMNS       = 12,
  parameter  int         ROWS          = 2,
  parameter  int         FONT_NUM_CHAR = 256,
  parameter  logic [7:0] CLEAR_CHAR    = 8'h20,
  localparam int         CW            = $clog2(FONT_NUM_CHAR),
  localparam int         XW            = $clog2(COLUMNS),
  localparam int         YW            = $clog2(ROWS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CW-1:0] i_char,
  input  logic          i_char_valid,
  output logic          o_char_ready,
  input  logic          i_clear,
  input  logic          i_vblank,
  output logic          o_wr_en,
  output logic [CW-1:0] o_wr_character,
  output logic [XW-1:0] o_wr_x_pos,
  output logic [YW-1:0] o_wr_y_pos,
  output logic [XW-1:0] o_cur_x,
  output logic [YW-1:0] o_cur_y,
  output logic          o_busy
);

  state_t        state_q;
  state_t        state_nxt;
  // Keeps ready low while reset is asserted and for the first cycle after it.
  logic          armed_q;
  logic [CW-1:0] char_q;
  logic [XW-1:0] wx_q;
  logic [YW-1:0] wy_q;
  logic [XW-1:0] sx_q;
  logic [YW-1:0] sy_q;

  logic is_lf, is_cr, is_bs, is_ff, is_ctrl;
  logic accept, accept_print, start_clear;
  logic wr_go, sweep_step, sweep_last;

  assign is_lf   = (i_char == CW'(CC_LF));
  assign is_cr   = (i_char == CW'(CC_CR));
  assign is_bs   = (i_char == CW'(CC_BS));
  assign is_ff   = (i_char == CW'(CC_FF));
  assign is_ctrl = is_lf | is_cr | is_bs | is_ff;

  // A clear request outranks a simultaneous character.
  assign o_char_ready = armed_q && (state_q == IDLE) && !i_clear;
  assign accept       = o_char_ready && i_char_valid;
  assign accept_print = accept && !is_ctrl;
  assign start_clear  = armed_q && (state_q == IDLE) && (i_clear || (accept && is_ff));

`ifdef CHAR_WR_VBLANK_ONLY_EN
  assign wr_go = i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = i_vblank;
  assign wr_go         = 1'b1;
`endif

  assign sweep_step = (state_q == CLEAR) && wr_go;
  assign sweep_last = (sx_q == XW'(COLUMNS - 1)) && (sy_q == YW'(ROWS - 1));

  text_cursor #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS)
  ) u_cursor (
    .clk             (i_clk),
    .rst_n           (i_rst_n),
    .advance         (accept_print),
    .retreat         (accept && is_bs),
    .newline         (accept && is_lf),
    .carriage_return (accept && is_cr),
    .home            (sweep_step && sweep_last),
    .x               (o_cur_x),
    .y               (o_cur_y)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (start_clear) begin
          state_nxt = CLEAR;
        end else if (accept_print) begin
`ifdef CHAR_WR_VBLANK_ONLY_EN
          state_nxt = HOLD;
`else
          state_nxt = WRITE;
`endif
        end
      end
      WRITE: begin
        if (wr_go) state_nxt = IDLE;
      end
      CLEAR: begin
        if (sweep_step && sweep_last) state_nxt = IDLE;
      end
      HOLD: begin
`ifdef CHAR_WR_VBLANK_ONLY_EN
        if (i_vblank) state_nxt = WRITE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wr_en        = 1'b0;
    o_wr_character = '0;
    o_wr_x_pos     = '0;
    o_wr_y_pos     = '0;
    o_busy         = 1'b0;
    case (state_q)
      WRITE: begin
        o_wr_en        = wr_go;
        o_wr_character = char_q;
        o_wr_x_pos     = wx_q;
        o_wr_y_pos     = wy_q;
        o_busy         = 1'b1;
      end
      CLEAR: begin
        o_wr_en        = wr_go;
        o_wr_character = CW'(CLEAR_CHAR);
        o_wr_x_pos     = sx_q;
        o_wr_y_pos     = sy_q;
        o_busy         = 1'b1;
      end
      HOLD: begin
        o_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // The write address is the cursor at acceptance; the cursor itself moves
  // on the same edge, so it already shows the next cell during the write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      char_q <= '0;
      wx_q   <= '0;
      wy_q   <= '0;
    end else if (accept_print) begin
      char_q <= i_char;
      wx_q   <= o_cur_x;
      wy_q   <= o_cur_y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (start_clear) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (sweep_step) begin
      if (sx_q == XW'(COLUMNS - 1)) begin
        sx_q <= '0;
        sy_q <= (sy_q == YW'(ROWS - 1)) ? '0 : sy_q + YW'(1);
      end else begin
        sx_q <= sx_q + XW'(1);
      end
    end
  end

endmodule
